// File: rtl/core_io_pkg.sv
// Shared widths, frame slice offsets and serializer states for the Core result bus.
package core_io_pkg;
   localparam int MUL_PACK_W = 432;
   localparam int ADD_PACK_W = 432;
   localparam int SINGLE_W   = 27;
   localparam int FRAME_W    = 918;

   localparam int MUL_LSB        = 0;
   localparam int ADD_LSB        = 432;
   localparam int ADD_SINGLE_LSB = 864;
   localparam int SIGMOID_LSB    = 891;

   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, left-shifting register with MSB tap; load/shift take effect next edge.
// No flow control of its own: the owner stalls it by holding shift low.
module piso_shift_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         msb
);
   logic [W-1:0] shreg;

   always_ff @(posedge clk) begin
      if (rst)
         shreg <= '0;
      else if (load)
         shreg <= din;
      else if (shift)
         shreg <= {shreg[W-2:0], 1'b0};
   end

   assign msb = shreg[W-1];
endmodule

// File: rtl/core_result_serializer.sv
// Snapshots Core results and streams them MSB-first plus even parity; first bit one cycle after capture.
// out_ready low freezes the stream in place; capture requests while busy are dropped and flagged.
module core_result_serializer #(
   parameter int FRAME_W = core_io_pkg::FRAME_W,
   parameter int CNT_W   = 10
) (
   input  logic                              clk_pll,
   input  logic                              rst,
   input  logic                              capture_req,
   input  logic [core_io_pkg::MUL_PACK_W-1:0] mul_out_pack,
   input  logic [core_io_pkg::ADD_PACK_W-1:0] add_out_pack,
   input  logic [core_io_pkg::SINGLE_W-1:0]   add_out_single,
   input  logic [core_io_pkg::SINGLE_W-1:0]   sigmoid,
   input  logic                              out_ready,
   output logic                              out,
   output logic                              out_valid,
   output logic                              frame_start,
   output logic                              busy,
   output logic                              done,
   output logic                              overrun
);
   import core_io_pkg::*;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

   state_t             state, state_next;
   logic [CNT_W-1:0]   cnt;
   logic               parity;
   logic               shreg_msb;
   logic               load, shift, finish;
   logic [FRAME_W-1:0] frame;

   always_comb begin
      frame = '0;
      frame[MUL_LSB        +: MUL_PACK_W] = mul_out_pack;
      frame[ADD_LSB        +: ADD_PACK_W] = add_out_pack;
      frame[ADD_SINGLE_LSB +: SINGLE_W]   = add_out_single;
      frame[SIGMOID_LSB    +: SINGLE_W]   = sigmoid;
   end

   piso_shift_reg #(.W(FRAME_W)) u_shreg (
      .clk   (clk_pll),
      .rst   (rst),
      .load  (load),
      .shift (shift),
      .din   (frame),
      .msb   (shreg_msb)
   );

   always_ff @(posedge clk_pll) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next  = state;
      load        = 1'b0;
      shift       = 1'b0;
      finish      = 1'b0;
      out         = 1'b0;
      out_valid   = 1'b0;
      frame_start = 1'b0;
      busy        = 1'b0;
      case (state)
         IDLE: begin
            if (capture_req) begin
               load       = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            out         = shreg_msb;
            out_valid   = 1'b1;
            busy        = 1'b1;
            frame_start = (cnt == '0);
            if (out_ready) begin
               shift = 1'b1;
               if (cnt == LAST_CNT)
                  state_next = PARITY;
            end
         end
         PARITY: begin
            out       = parity;
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Parity accumulates each data bit as it is accepted, so it is ready when the last bit leaves.
   always_ff @(posedge clk_pll) begin
      if (rst) begin
         cnt     <= '0;
         parity  <= 1'b0;
         done    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         done <= finish;
         if (capture_req && state != IDLE)
            overrun <= 1'b1;
         if (load) begin
            cnt    <= '0;
            parity <= 1'b0;
         end else if (shift) begin
            cnt    <= cnt + CNT_W'(1);
            parity <= parity ^ shreg_msb;
         end
      end
   end
endmodule

// File: tb/tb_core_result_serializer.sv
// Directed bench for core_result_serializer: per-cycle compare against a frame-position model plus literal checks.
module tb_core_result_serializer;
   logic         clk_pll = 1'b0;
   logic         rst = 1'b1;
   logic         capture_req = 1'b0;
   logic         out_ready = 1'b1;
   logic [917:0] drv_frame = '0;
   logic [431:0] mul_out_pack, add_out_pack;
   logic [26:0]  add_out_single, sigmoid;
   logic         out, out_valid, frame_start, busy, done, overrun;

   assign mul_out_pack   = drv_frame[431:0];
   assign add_out_pack   = drv_frame[863:432];
   assign add_out_single = drv_frame[890:864];
   assign sigmoid        = drv_frame[917:891];

   core_result_serializer dut (
      .clk_pll        (clk_pll),
      .rst            (rst),
      .capture_req    (capture_req),
      .mul_out_pack   (mul_out_pack),
      .add_out_pack   (add_out_pack),
      .add_out_single (add_out_single),
      .sigmoid        (sigmoid),
      .out_ready      (out_ready),
      .out            (out),
      .out_valid      (out_valid),
      .frame_start    (frame_start),
      .busy           (busy),
      .done           (done),
      .overrun        (overrun)
   );

   always #5 clk_pll = ~clk_pll;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Model: position within the 919-beat sequence (-1 when no frame is in flight).
   int           cyc = 0;
   int           m_pos = -1;
   logic [917:0] m_snap = '0;
   bit           m_done = 1'b0;
   bit           m_ovr = 1'b0;

   always @(posedge clk_pll) begin
      cyc <= cyc + 1;
      if (rst) begin
         m_pos  <= -1;
         m_done <= 1'b0;
         m_ovr  <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_pos < 0) begin
            if (capture_req) begin
               m_snap <= drv_frame;
               m_pos  <= 0;
            end
         end else begin
            if (capture_req) m_ovr <= 1'b1;
            if (out_ready) begin
               if (m_pos == 918) begin
                  m_pos  <= -1;
                  m_done <= 1'b1;
               end else begin
                  m_pos <= m_pos + 1;
               end
            end
         end
      end
   end

   always @(negedge clk_pll) begin
      if (cyc > 0) begin
         logic e_vld, e_out;
         e_vld = (m_pos >= 0);
         e_out = 1'b0;
         if (m_pos >= 0 && m_pos < 918) e_out = m_snap[917 - m_pos];
         else if (m_pos == 918)         e_out = ^m_snap;
         chk($sformatf("cycle_model@%0d", cyc),
             {26'd0, out_valid, out, frame_start, busy, done, overrun},
             {26'd0, e_vld, e_out, (m_pos == 0), e_vld, m_done, m_ovr});
      end
   end

   bit   rx[$];
   int   done_at, fs_cnt, fs_at, vld_cnt;
   logic obs_out [0:2100];

   task automatic run_frame(input logic [917:0] f, input bit alt, input int inj_cyc,
                            input logic [917:0] inj_f, input int rst_cyc);
      logic       prev_stall;
      logic [2:0] prev_o;
      rx.delete();
      done_at = -1; fs_cnt = 0; fs_at = -1; vld_cnt = 0;
      prev_stall = 1'b0; prev_o = '0;
      @(posedge clk_pll); #1;
      drv_frame = f; capture_req = 1'b1; out_ready = 1'b1;
      for (int k = 1; k <= 2100; k++) begin
         @(posedge clk_pll); #1;
         capture_req = (k == inj_cyc);
         if (k == 2) drv_frame = ~f;
         if (k == inj_cyc) drv_frame = inj_f;
         rst = (k == rst_cyc);
         out_ready = alt ? ((k % 2) == 1) : 1'b1;
         @(negedge clk_pll);
         obs_out[k] = out;
         if (prev_stall) chk("stall_hold", {29'd0, out_valid, out, frame_start}, {29'd0, prev_o});
         prev_stall = out_valid && !out_ready;
         prev_o     = {out_valid, out, frame_start};
         if (out_valid) vld_cnt++;
         if (frame_start) begin
            fs_cnt++;
            if (fs_at < 0) fs_at = k;
         end
         if (out_valid && out_ready) rx.push_back(out);
         if (inj_cyc > 0 && k == inj_cyc + 1) chk("overrun_set", overrun, 1);
         if (rst_cyc > 0 && k == rst_cyc + 1) begin
            chk("rst_abort_valid", out_valid, 0);
            chk("rst_abort_busy", busy, 0);
            chk("rst_abort_overrun", overrun, 0);
         end
         if (done) begin
            done_at = k;
            break;
         end
         if (rst_cyc > 0 && k == rst_cyc + 2) break;
      end
      capture_req = 1'b0;
      rst = 1'b0;
   endtask

   task automatic check_rx(input string tag, input logic [917:0] f);
      logic [917:0] got;
      int           diff;
      got = '0; diff = 0;
      chk({tag, "_rx_len"}, rx.size(), 919);
      if (rx.size() == 919) begin
         for (int i = 0; i < 918; i++) got[917 - i] = rx[i];
         for (int i = 0; i < 918; i++) if (got[i] != f[i]) diff++;
         chk({tag, "_rx_diffbits"}, diff, 0);
         chk({tag, "_rx_parity"}, rx[918], ^f);
      end
   endtask

   function automatic logic [917:0] rand_frame();
      logic [917:0] r;
      for (int i = 0; i < 918; i++) r[i] = 1'($urandom_range(0, 1));
      return r;
   endfunction

   initial begin
      logic [917:0] f, g;
      int ones;

      // Reset held with capture_req asserted: nothing may start.
      capture_req = 1'b1; drv_frame = rand_frame();
      repeat (3) @(posedge clk_pll);
      @(negedge clk_pll);
      chk("reset_outputs", {26'd0, out_valid, out, frame_start, busy, done, overrun}, 0);
      @(posedge clk_pll); #1;
      rst = 1'b0; capture_req = 1'b0;
      @(negedge clk_pll);
      chk("post_reset_idle", {28'd0, out_valid, busy, done, overrun}, 0);

      // Single set bit in mul_out_pack bit 0: last data bit and parity are 1.
      f = '0; f[0] = 1'b1;
      run_frame(f, 1'b0, 0, '0, 0);
      chk("lsb_valid_cycles", vld_cnt, 919);
      chk("lsb_frame_start_cnt", fs_cnt, 1);
      chk("lsb_frame_start_at", fs_at, 1);
      chk("lsb_out_c917", obs_out[917], 0);
      chk("lsb_out_c918", obs_out[918], 1);
      chk("lsb_parity_c919", obs_out[919], 1);
      chk("lsb_done_at", done_at, 920);
      check_rx("lsb", f);

      // sigmoid MSB only: first bit on the wire is 1.
      f = '0; f[917] = 1'b1;
      run_frame(f, 1'b0, 0, '0, 0);
      chk("sig_first_bit", obs_out[1], 1);
      chk("sig_parity_c919", obs_out[919], 1);
      chk("sig_done_at", done_at, 920);
      check_rx("sig", f);

      // All ones: 918 ones then even parity 0.
      f = '1;
      run_frame(f, 1'b0, 0, '0, 0);
      ones = 0;
      foreach (rx[i]) if (rx[i]) ones++;
      chk("ones_count", ones, 918);
      chk("ones_parity_c919", obs_out[919], 0);
      check_rx("ones", f);

      // Alternating backpressure with random payload.
      f = rand_frame();
      run_frame(f, 1'b1, 0, '0, 0);
      chk("bp_done_window", (done_at >= 1837 && done_at <= 1838), 1);
      check_rx("bp", f);

      // Capture while busy: original snapshot survives, overrun is sticky.
      f = rand_frame(); g = ~f;
      run_frame(f, 1'b0, 100, g, 0);
      chk("ovr_done_at", done_at, 920);
      chk("ovr_sticky_at_done", overrun, 1);
      check_rx("ovr", f);

      // Reset mid-frame aborts without done, then a fresh frame goes out whole.
      f = rand_frame();
      run_frame(f, 1'b0, 0, '0, 400);
      chk("rst_no_done", done_at, 32'hffffffff);
      f = rand_frame();
      run_frame(f, 1'b0, 0, '0, 0);
      chk("fresh_done_at", done_at, 920);
      chk("fresh_frame_start_at", fs_at, 1);
      check_rx("fresh", f);

      repeat (2) @(posedge clk_pll);
      @(negedge clk_pll);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
